startup_cmd_executor: RTL and testbench

//   Consumes the startup command byte stream (valid_a/data_a) from the configuration controller.

---
 rtl/startup_cmd_executor.sv | 153 +++++++++++++++
 tb/tb_startup_cmd_executor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/startup_cmd_executor.sv
// startup_cmd_executor
//   Executes startup commands from the configuration controller. Each command
//   burst on valid_a/data_a is decoded on its first beat (8'h52 BIST, 8'h53
//   CONFIG, 8'h54 LOAD). The matching *_run strobe is then held for the
//   configured number of cycles, and a sticky *_done flag is raised at the end.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   valid_a      command byte valid (a command is >=1 contiguous beats)
//   data_a       command byte
//   bist_done    sticky: last BIST finished
//   config_done  sticky: last CONFIG finished
//   load_done    sticky: last LOAD finished
//   bist_run     high while a BIST op executes
//   cfg_run      high while a CONFIG op executes
//   load_run     high while a LOAD op executes
//   busy         an op is executing
//   cmd_error    one-cycle pulse: bad opcode, or new command while busy
//
// state  | meaning
// -------+------------------------------------------
// IDLE   | waiting for the first beat of a command
// BIST   | bist_run asserted, counting down
// CONFIG | cfg_run asserted, counting down
// LOAD   | load_run asserted, counting down

module startup_cmd_executor #(
    parameter int BIST_CYCLES   = 16,
    parameter int CONFIG_CYCLES = 8,
    parameter int LOAD_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_a,
    input  logic [7:0] data_a,
    output logic       bist_done,
    output logic       config_done,
    output logic       load_done,
    output logic       bist_run,
    output logic       cfg_run,
    output logic       load_run,
    output logic       busy,
    output logic       cmd_error
);

    localparam int MAX_BC = (BIST_CYCLES > CONFIG_CYCLES) ? BIST_CYCLES : CONFIG_CYCLES;
    localparam int MAX_C  = (MAX_BC > LOAD_CYCLES) ? MAX_BC : LOAD_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] BIST_START   = CNT_W'(BIST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONFIG_START = CNT_W'(CONFIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_START   = CNT_W'(LOAD_CYCLES - 1);

    localparam logic [7:0] OP_BIST   = 8'h52;
    localparam logic [7:0] OP_CONFIG = 8'h53;
    localparam logic [7:0] OP_LOAD   = 8'h54;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIST,
        S_CONFIG,
        S_LOAD
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             valid_q;
    logic             first_beat;
    logic             bist_done_nx, config_done_nx, load_done_nx;
    logic             cmd_error_nx;

    // Only the rising edge of valid_a starts a command; trailing beats of the
    // same burst are ignored whatever their data.
    assign first_beat = valid_a & ~valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            valid_q     <= 1'b0;
            bist_done   <= 1'b0;
            config_done <= 1'b0;
            load_done   <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            valid_q     <= valid_a;
            bist_done   <= bist_done_nx;
            config_done <= config_done_nx;
            load_done   <= load_done_nx;
            cmd_error   <= cmd_error_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        bist_done_nx   = bist_done;
        config_done_nx = config_done;
        load_done_nx   = load_done;
        cmd_error_nx   = 1'b0;

        if (state == S_IDLE) begin
            if (first_beat) begin
                if (data_a == OP_BIST || data_a == OP_CONFIG || data_a == OP_LOAD) begin
                    bist_done_nx   = 1'b0;
                    config_done_nx = 1'b0;
                    load_done_nx   = 1'b0;
                end
                case (data_a)
                    OP_BIST: begin
                        state_nx = S_BIST;
                        cnt_nx   = BIST_START;
                    end
                    OP_CONFIG: begin
                        state_nx = S_CONFIG;
                        cnt_nx   = CONFIG_START;
                    end
                    OP_LOAD: begin
                        state_nx = S_LOAD;
                        cnt_nx   = LOAD_START;
                    end
                    default: cmd_error_nx = 1'b1;
                endcase
            end
        end else begin
            // A command arriving on the completing cycle is still rejected;
            // the sender is expected to wait for done.
            if (first_beat) begin
                cmd_error_nx = 1'b1;
            end
            if (cnt == '0) begin
                state_nx = S_IDLE;
                case (state)
                    S_BIST:   bist_done_nx   = 1'b1;
                    S_CONFIG: config_done_nx = 1'b1;
                    S_LOAD:   load_done_nx   = 1'b1;
                    default:  ;
                endcase
            end else begin
                cnt_nx = cnt - CNT_W'(1);
            end
        end
    end

    assign bist_run = (state == S_BIST);
    assign cfg_run  = (state == S_CONFIG);
    assign load_run = (state == S_LOAD);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_startup_cmd_executor.sv
module tb_startup_cmd_executor;

    localparam int BC = 16;
    localparam int CC = 8;
    localparam int LC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       v1 = 1'b0;
    logic [7:0] d1 = 8'h00;

    logic bist_done, config_done, load_done, bist_run, cfg_run, load_run, busy, cmd_error;
    logic bist_done1, config_done1, load_done1, bist_run1, cfg_run1, load_run1, busy1, cmd_error1;

    // {cmd_error, busy, bist_run, cfg_run, load_run, bist_done, config_done, load_done}
    logic [7:0] outs, outs1;
    assign outs  = {cmd_error, busy, bist_run, cfg_run, load_run, bist_done, config_done, load_done};
    assign outs1 = {cmd_error1, busy1, bist_run1, cfg_run1, load_run1, bist_done1, config_done1, load_done1};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    startup_cmd_executor #(.BIST_CYCLES(BC), .CONFIG_CYCLES(CC), .LOAD_CYCLES(LC)) dut (
        .clk(clk), .rst_n(rst_n), .valid_a(valid_a), .data_a(data_a),
        .bist_done(bist_done), .config_done(config_done), .load_done(load_done),
        .bist_run(bist_run), .cfg_run(cfg_run), .load_run(load_run),
        .busy(busy), .cmd_error(cmd_error)
    );

    startup_cmd_executor #(.BIST_CYCLES(1), .CONFIG_CYCLES(1), .LOAD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_a(v1), .data_a(d1),
        .bist_done(bist_done1), .config_done(config_done1), .load_done(load_done1),
        .bist_run(bist_run1), .cfg_run(cfg_run1), .load_run(load_run1),
        .busy(busy1), .cmd_error(cmd_error1)
    );

    // Reference model: time-based. An accepted op of length C at edge N keeps
    // the block busy for edges N..N+C-1 (as seen after each edge); the done
    // flag of the last accepted op is visible whenever the block is not busy.
    int         m_edge = 0;
    int         m_end = 0;
    int         m_op = 0;      // 0 none, 1 BIST, 2 CONFIG, 3 LOAD
    logic       m_prev_v = 1'b0;
    logic       m_err = 1'b0;
    logic       m_first, m_busy_before, m_good;

    assign m_first       = valid_a && !m_prev_v;
    assign m_busy_before = (m_edge < m_end);
    assign m_good        = (data_a >= 8'h52) && (data_a <= 8'h54);

    function automatic int cyc_of(input int op);
        case (op)
            1: return BC;
            2: return CC;
            default: return LC;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op     <= 0;
            m_end    <= m_edge;
            m_prev_v <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_err <= m_first && (m_busy_before || !m_good);
            if (m_first && !m_busy_before && m_good) begin
                m_op  <= int'(data_a) - 8'h51;
                m_end <= m_edge + 1 + cyc_of(int'(data_a) - 8'h51);
            end
            m_edge   <= m_edge + 1;
            m_prev_v <= valid_a;
        end
    end

    function automatic logic [7:0] model_vec();
        logic b;
        b = (m_edge < m_end);
        return {m_err, b, b && m_op == 1, b && m_op == 2, b && m_op == 3,
                !b && m_op == 1, !b && m_op == 2, !b && m_op == 3};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs (at a negedge), take one clock, compare against the model.
    task automatic step(input logic v, input logic [7:0] d);
        valid_a = v;
        data_a  = d;
        @(posedge clk);
        @(negedge clk);
        chk("model", outs, model_vec());
    endtask

    // Issue one command and wait (bounded) for its done flag.
    task automatic run_cmd(input logic [7:0] code, input int cyc, input int run_bit,
                           input int done_bit, input string name);
        int  n;
        bit  got;
        n   = 0;
        got = 0;
        step(1'b1, code);
        chk({name, "_clear"}, {5'b0, outs[2:0]}, 8'h00);
        for (int k = 0; k < 40; k++) begin
            if (outs[run_bit]) n++;
            if (outs[done_bit]) begin
                got = 1;
                break;
            end
            step(1'b0, 8'h00);
        end
        chk_int({name, "_done_seen"}, int'(got), 1);
        chk_int({name, "_run_cycles"}, n, cyc);
    endtask

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int cfg_seen;
        int rsel;

        tbl[0]  = '{1'b1, 8'h55, 8'b1000_0000};
        tbl[1]  = '{1'b1, 8'h54, 8'b0000_0000};
        tbl[2]  = '{1'b0, 8'h00, 8'b0000_0000};
        tbl[3]  = '{1'b1, 8'h54, 8'b0100_1000};
        tbl[4]  = '{1'b1, 8'h52, 8'b0100_1000};
        tbl[5]  = '{1'b0, 8'h00, 8'b0100_1000};
        tbl[6]  = '{1'b1, 8'h53, 8'b1100_1000};
        tbl[7]  = '{1'b0, 8'h00, 8'b0000_0001};
        tbl[8]  = '{1'b0, 8'h00, 8'b0000_0001};
        tbl[9]  = '{1'b1, 8'h57, 8'b1000_0001};
        tbl[10] = '{1'b0, 8'h00, 8'b0000_0001};

        @(negedge clk);
        @(negedge clk);
        chk("reset_state", outs, 8'h00);
        chk("reset_state1", outs1, 8'h00);
        rst_n = 1'b1;
        step(1'b0, 8'h00);
        chk("idle_after_reset", outs, 8'h00);

        // Vector table: bad opcode, ignored trailing beats, LOAD, busy reject.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d", i), outs, tbl[i].exp);
        end

        // 2-beat BIST burst; second beat must not retrigger.
        for (int k = 0; k <= 18; k++) begin
            step(k < 2, 8'h52);
            if (k < 16) chk($sformatf("bist_run_k%0d", k), outs & 8'b0110_0111, 8'b0110_0000);
            else        chk($sformatf("bist_done_k%0d", k), outs, 8'b0000_0100);
        end

        // CONFIG burst in run cycle 5 of a BIST: rejected, BIST timing unchanged.
        cfg_seen = 0;
        for (int k = 0; k <= 16; k++) begin
            step(k == 0 || k == 5 || k == 6, (k == 0) ? 8'h52 : 8'h53);
            if (cfg_run) cfg_seen++;
            if (k == 5)  chk("busy_reject_err", {7'b0, cmd_error}, 8'h01);
            if (k == 6)  chk("busy_reject_pulse", {7'b0, cmd_error}, 8'h00);
            if (k < 16)  chk($sformatf("bist2_run_k%0d", k), {7'b0, bist_run}, 8'h01);
            else         chk("bist2_done", outs, 8'b0000_0100);
        end
        chk_int("cfg_never_ran", cfg_seen, 0);

        // BIST -> CONFIG -> LOAD chain.
        step(1'b0, 8'h00);
        run_cmd(8'h52, BC, 5, 2, "seq_bist");
        chk("seq_bist_flags", {5'b0, outs[2:0]}, 8'b100);
        step(1'b0, 8'h00);
        run_cmd(8'h53, CC, 4, 1, "seq_cfg");
        chk("seq_cfg_flags", {5'b0, outs[2:0]}, 8'b010);
        step(1'b0, 8'h00);
        run_cmd(8'h54, LC, 3, 0, "seq_load");
        chk("seq_load_flags", {5'b0, outs[2:0]}, 8'b001);

        // Reset in the middle of a LOAD.
        step(1'b0, 8'h00);
        step(1'b1, 8'h54);
        step(1'b0, 8'h00);
        chk("mid_load", outs, 8'b0100_1000);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", outs, 8'h00);
        #1 rst_n = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("after_abort", outs, 8'h00);

        // One-cycle ops.
        v1 = 1'b1;
        d1 = 8'h54;
        step(1'b0, 8'h00);
        chk("c1_run", outs1, 8'b0100_1000);
        v1 = 1'b0;
        step(1'b0, 8'h00);
        chk("c1_done", outs1, 8'b0000_0001);
        step(1'b0, 8'h00);
        chk("c1_hold", outs1, 8'b0000_0001);

        // Randomized traffic, with occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                valid_a = 1'($urandom_range(0, 1));
                #2 rst_n = 1'b0;
                #1 chk("rand_async_reset", outs, 8'h00);
                #1 rst_n = 1'b1;
            end
            rsel = $urandom_range(0, 7);
            step($urandom_range(0, 2) == 0,
                 (rsel < 2) ? 8'h52 : (rsel == 2) ? 8'h53 : (rsel < 5) ? 8'h54 :
                 (rsel == 5) ? 8'h55 : 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
